regfile_2r1w: RTL and testbench

- 32-entry, 2-read/1-write register file for the pipelined LEGv8 CPU.
- Sits directly upstream of the ALU-operand / forwarding mux4_1 selectors. Its ReadData1/ReadData2 outputs drive the w0 inputs of those muxes.
- Synchronous write, combinational read.
- Register 31 is the hardwired zero register (XZR).
- Same-cycle write-to-read bypass, so decode sees the value being written back this cycle.

---
 rtl/regfile_2r1w.sv | 159 +++++++++++++++
 tb/tb_regfile_2r1w.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_2r1w.sv
// 2-read / 1-write register file with hardwired zero register and optional
// same-cycle write-to-read bypass; read decode is a mux4_1 tree per port.

module regfile_mux4_1 #(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0] w0_i,
  input  logic [DATA_W-1:0] w1_i,
  input  logic [DATA_W-1:0] w2_i,
  input  logic [DATA_W-1:0] w3_i,
  input  logic [1:0]        s_i,
  output logic [DATA_W-1:0] y_o
);

  always_comb begin
    unique case (s_i)
      2'd0:    y_o = w0_i;
      2'd1:    y_o = w1_i;
      2'd2:    y_o = w2_i;
      default: y_o = w3_i;
    endcase
  end

endmodule

module regfile_2r1w_rdtree #(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 32,
  localparam int IDX_W   = $clog2(NUM_REGS)
) (
  input  logic [NUM_REGS-1:0][DATA_W-1:0] entries_i,
  input  logic [IDX_W-1:0]                idx_i,
  output logic [DATA_W-1:0]               data_o
);

  localparam int L4  = IDX_W / 2;
  localparam bit ODD = (IDX_W % 2) != 0;

  // All tree levels live in one flat array; level k starts at lvl_off(k).
  function automatic int lvl_off(input int k);
    int o;
    int n;
    o = 0;
    n = NUM_REGS;
    for (int i = 0; i < k; i++) begin
      o = o + n;
      n = n / 4;
    end
    return o;
  endfunction

  localparam int TOTAL = lvl_off(L4 + 1);

  logic [DATA_W-1:0] node [TOTAL];

  genvar k, j;
  generate
    for (j = 0; j < NUM_REGS; j++) begin : g_leaf
      assign node[j] = entries_i[j];
    end

    for (k = 0; k < L4; k++) begin : g_lvl
      for (j = 0; j < (NUM_REGS >> (2 * (k + 1))); j++) begin : g_node
        regfile_mux4_1 #(.DATA_W(DATA_W)) u_mux (
          .w0_i (node[lvl_off(k) + 4*j + 0]),
          .w1_i (node[lvl_off(k) + 4*j + 1]),
          .w2_i (node[lvl_off(k) + 4*j + 2]),
          .w3_i (node[lvl_off(k) + 4*j + 3]),
          .s_i  (idx_i[2*k+1:2*k]),
          .y_o  (node[lvl_off(k+1) + j])
        );
      end
    end

    // Odd index width leaves two survivors for a final 2:1 on the MSB.
    if (ODD) begin : g_odd
      assign data_o = idx_i[IDX_W-1] ? node[lvl_off(L4) + 1] : node[lvl_off(L4)];
    end else begin : g_even
      assign data_o = node[lvl_off(L4)];
    end
  endgenerate

endmodule

module regfile_2r1w #(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = 31,
  parameter int BYPASS   = 1,
  localparam int IDX_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              RegWrite,
  input  logic [IDX_W-1:0]  WriteRegister,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [IDX_W-1:0]  ReadRegister1,
  input  logic [IDX_W-1:0]  ReadRegister2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2
);

  localparam logic [IDX_W-1:0] ZERO_IDX = IDX_W'(ZERO_REG);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;
  logic [NUM_REGS-1:0][DATA_W-1:0] regs_d;
  logic [NUM_REGS-1:0]             wr_en;
  logic [DATA_W-1:0]               tree1;
  logic [DATA_W-1:0]               tree2;
  logic                            wr_live;

  assign wr_live = RegWrite && (WriteRegister != ZERO_IDX);

  always_comb begin
    wr_en = '0;
    if (wr_live) wr_en[WriteRegister] = 1'b1;
  end

  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_en[i]) regs_d[i] = WriteData;
    end
    regs_d[ZERO_REG] = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) regs_q <= '0;
    else          regs_q <= regs_d;
  end

  regfile_2r1w_rdtree #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_rd1 (
    .entries_i (regs_q),
    .idx_i     (ReadRegister1),
    .data_o    (tree1)
  );

  regfile_2r1w_rdtree #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_rd2 (
    .entries_i (regs_q),
    .idx_i     (ReadRegister2),
    .data_o    (tree2)
  );

  // Bypass is masked during reset so every index reads 0 while reset_n is low.
  always_comb begin
    ReadData1 = tree1;
    if ((BYPASS != 0) && reset_n && wr_live && (WriteRegister == ReadRegister1))
      ReadData1 = WriteData;
    if (ReadRegister1 == ZERO_IDX) ReadData1 = '0;
  end

  always_comb begin
    ReadData2 = tree2;
    if ((BYPASS != 0) && reset_n && wr_live && (WriteRegister == ReadRegister2))
      ReadData2 = WriteData;
    if (ReadRegister2 == ZERO_IDX) ReadData2 = '0;
  end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w: one instance with bypass, one without, sharing stimulus;
// expected read data is queued when stimulus is applied and popped on sampling.

module tb_regfile_2r1w;

  localparam int DATA_W = 64;
  localparam int IDX_W  = 5;

  logic              clk;
  logic              reset_n;
  logic              RegWrite;
  logic [IDX_W-1:0]  WriteRegister;
  logic [DATA_W-1:0] WriteData;
  logic [IDX_W-1:0]  ReadRegister1;
  logic [IDX_W-1:0]  ReadRegister2;
  logic [DATA_W-1:0] rd1_b, rd2_b, rd1_n, rd2_n;

  int vectors;
  int miscompares;
  logic [DATA_W-1:0] sb [$];
  logic [DATA_W-1:0] obs [4];
  string             pname [4];
  logic [DATA_W-1:0] exp_v;

  regfile_2r1w #(.DATA_W(64), .NUM_REGS(32), .ZERO_REG(31), .BYPASS(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
    .WriteData(WriteData), .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .ReadData1(rd1_b), .ReadData2(rd2_b)
  );

  regfile_2r1w #(.DATA_W(64), .NUM_REGS(32), .ZERO_REG(31), .BYPASS(0)) dut_n (
    .clk(clk), .reset_n(reset_n), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
    .WriteData(WriteData), .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .ReadData1(rd1_n), .ReadData2(rd2_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_write(input logic [IDX_W-1:0] idx, input logic [DATA_W-1:0] d);
    @(negedge clk);
    RegWrite      = 1'b1;
    WriteRegister = idx;
    WriteData     = d;
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
  endtask

  // Expected values are pushed in port order: byp rd1, byp rd2, nobyp rd1, nobyp rd2.
  task automatic push4(input logic [DATA_W-1:0] b1, input logic [DATA_W-1:0] b2,
                       input logic [DATA_W-1:0] n1, input logic [DATA_W-1:0] n2);
    sb.push_back(b1);
    sb.push_back(b2);
    sb.push_back(n1);
    sb.push_back(n2);
  endtask

  task automatic test_reset(input string tag);
    reset_n = 1'b0;
    RegWrite = 1'b0;
    WriteRegister = '0;
    WriteData = '0;
    ReadRegister1 = 5'd5;
    ReadRegister2 = 5'd0;
    push4(0, 0, 0, 0);
    #3;
    obs = '{rd1_b, rd2_b, rd1_n, rd2_n};
    for (int p = 0; p < 4; p++) begin
      exp_v = sb.pop_front();
      vectors++;
      if (obs[p] !== exp_v) begin
        miscompares++;
        $display("FAIL %s %s: got %h want %h", tag, pname[p], obs[p], exp_v);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset_midcycle();
    do_write(5'd5, 64'hDEAD);
    ReadRegister1 = 5'd5;
    ReadRegister2 = 5'd5;
    for (int ph = 0; ph < 4; ph++) begin
      case (ph)
        0: push4(64'hDEAD, 64'hDEAD, 64'hDEAD, 64'hDEAD);
        1: begin
          @(posedge clk);
          #3 reset_n = 1'b0;
          push4(0, 0, 0, 0);
        end
        2: begin
          RegWrite = 1'b1; WriteRegister = 5'd5; WriteData = 64'hBEEF;
          @(posedge clk);
          push4(0, 0, 0, 0);
        end
        default: begin
          @(negedge clk);
          reset_n = 1'b1;
          RegWrite = 1'b0;
          @(posedge clk);
          push4(0, 0, 0, 0);
        end
      endcase
      #1;
      obs = '{rd1_b, rd2_b, rd1_n, rd2_n};
      for (int p = 0; p < 4; p++) begin
        exp_v = sb.pop_front();
        vectors++;
        if (obs[p] !== exp_v) begin
          miscompares++;
          $display("FAIL reset_mid ph%0d %s: got %h want %h", ph, pname[p], obs[p], exp_v);
        end
      end
    end
  endtask

  task automatic test_basic();
    do_write(5'd3, 64'h0123456789ABCDEF);
    do_write(5'd7, 64'hFFFFFFFFFFFFFFFF);
    for (int ph = 0; ph < 2; ph++) begin
      @(negedge clk);
      if (ph == 0) begin
        ReadRegister1 = 5'd3;
        ReadRegister2 = 5'd7;
        push4(64'h0123456789ABCDEF, 64'hFFFFFFFFFFFFFFFF,
              64'h0123456789ABCDEF, 64'hFFFFFFFFFFFFFFFF);
      end else begin
        ReadRegister1 = 5'd4;
        ReadRegister2 = 5'd4;
        push4(0, 0, 0, 0);
      end
      #1;
      obs = '{rd1_b, rd2_b, rd1_n, rd2_n};
      for (int p = 0; p < 4; p++) begin
        exp_v = sb.pop_front();
        vectors++;
        if (obs[p] !== exp_v) begin
          miscompares++;
          $display("FAIL basic ph%0d %s: got %h want %h", ph, pname[p], obs[p], exp_v);
        end
      end
    end
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    ReadRegister1 = 5'd31;
    ReadRegister2 = 5'd31;
    RegWrite = 1'b1; WriteRegister = 5'd31; WriteData = 64'h55;
    for (int ph = 0; ph < 2; ph++) begin
      if (ph == 1) begin
        @(posedge clk);
        #1 RegWrite = 1'b0;
      end
      push4(0, 0, 0, 0);
      #1;
      obs = '{rd1_b, rd2_b, rd1_n, rd2_n};
      for (int p = 0; p < 4; p++) begin
        exp_v = sb.pop_front();
        vectors++;
        if (obs[p] !== exp_v) begin
          miscompares++;
          $display("FAIL zero_reg ph%0d %s: got %h want %h", ph, pname[p], obs[p], exp_v);
        end
      end
    end
  endtask

  task automatic test_bypass();
    do_write(5'd9, 64'h10);
    @(negedge clk);
    ReadRegister1 = 5'd9;
    ReadRegister2 = 5'd9;
    RegWrite = 1'b1; WriteRegister = 5'd9; WriteData = 64'h20;
    for (int ph = 0; ph < 2; ph++) begin
      if (ph == 0) begin
        push4(64'h20, 64'h20, 64'h10, 64'h10);
      end else begin
        @(posedge clk);
        push4(64'h20, 64'h20, 64'h20, 64'h20);
      end
      #1;
      obs = '{rd1_b, rd2_b, rd1_n, rd2_n};
      for (int p = 0; p < 4; p++) begin
        exp_v = sb.pop_front();
        vectors++;
        if (obs[p] !== exp_v) begin
          miscompares++;
          $display("FAIL bypass ph%0d %s: got %h want %h", ph, pname[p], obs[p], exp_v);
        end
      end
    end
    RegWrite = 1'b0;
  endtask

  task automatic test_write_disable();
    do_write(5'd2, 64'h11);
    @(negedge clk);
    ReadRegister1 = 5'd2;
    ReadRegister2 = 5'd2;
    RegWrite = 1'b0; WriteRegister = 5'd2; WriteData = 64'hAA;
    for (int ph = 0; ph < 2; ph++) begin
      if (ph == 1) @(posedge clk);
      push4(64'h11, 64'h11, 64'h11, 64'h11);
      #1;
      obs = '{rd1_b, rd2_b, rd1_n, rd2_n};
      for (int p = 0; p < 4; p++) begin
        exp_v = sb.pop_front();
        vectors++;
        if (obs[p] !== exp_v) begin
          miscompares++;
          $display("FAIL wr_disable ph%0d %s: got %h want %h", ph, pname[p], obs[p], exp_v);
        end
      end
    end
  endtask

  task automatic test_sweep();
    logic [DATA_W-1:0] e1, e2;
    for (int i = 0; i < 31; i++) do_write(IDX_W'(i), DATA_W'(i) * 64'h0101);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      ReadRegister1 = IDX_W'(i);
      ReadRegister2 = IDX_W'(31 - i);
      e1 = (i == 31) ? 64'd0 : DATA_W'(i) * 64'h0101;
      e2 = (i == 0)  ? 64'd0 : DATA_W'(31 - i) * 64'h0101;
      push4(e1, e2, e1, e2);
      #1;
      obs = '{rd1_b, rd2_b, rd1_n, rd2_n};
      for (int p = 0; p < 4; p++) begin
        exp_v = sb.pop_front();
        vectors++;
        if (obs[p] !== exp_v) begin
          miscompares++;
          $display("FAIL sweep i=%0d %s: got %h want %h", i, pname[p], obs[p], exp_v);
        end
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    pname = '{"byp_rd1", "byp_rd2", "nobyp_rd1", "nobyp_rd2"};
    test_reset("reset_init");
    test_reset_midcycle();
    test_basic();
    test_zero_reg();
    test_bypass();
    test_write_disable();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
